// File: rtl/eh2_posit_encode_pipe.sv
// Posit encoder: packs sign/regime/exponent/fraction fields into a POSIT_LEN-bit posit with
// round-to-nearest-even, as a two-stage elastic pipeline (body build, then round/clamp/negate).
module eh2_posit_encode_pipe #(
    parameter int POSIT_LEN   = 32,
    parameter int ES          = 2,
    parameter int REGIME_BW   = $clog2(POSIT_LEN),
    parameter int FRACTION_BW = POSIT_LEN - ES - 3
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [REGIME_BW:0]     in_regime,
    input  logic [ES-1:0]          in_exponent,
    input  logic [FRACTION_BW-1:0] in_fraction,
    input  logic                   in_guard,
    input  logic                   in_sticky,
    input  logic                   in_zero,
    input  logic                   in_nar,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [POSIT_LEN-1:0]   out_posit
);

    localparam int BW     = 2 * POSIT_LEN;
    localparam int TAIL_W = ES + FRACTION_BW + 1;
    localparam int KW     = REGIME_BW + 2;
    localparam int RUN_W  = REGIME_BW + 1;
    localparam logic signed [KW-1:0] K_MAX = KW'(POSIT_LEN - 2);
    localparam logic signed [KW-1:0] K_MIN = KW'(-(POSIT_LEN - 1));
    localparam logic [POSIT_LEN:0]   MAXPOS = {2'b00, {(POSIT_LEN-1){1'b1}}};

    // Handshake: a side transfers on the edge where valid & ready are both high. Stage 1 may
    // advance when stage 2 is empty or draining, so out_ready -> in_ready is the only comb path.
    logic s1_valid_q, s2_valid_q, s1_move;
    assign s1_move   = ~s2_valid_q | out_ready;
    assign in_ready  = ~s1_valid_q | s1_move;
    assign out_valid = s2_valid_q;

    // ---------------- stage 1: clamp k, lay out regime + tail ----------------
    logic signed [KW-1:0] k_ext, k_c;
    logic                 sat_hi, sat_lo, k_neg, term;
    logic [RUN_W-1:0]     run, rl;
    logic [BW-1:0]        regime_pat, tail_al, body;

    assign k_ext  = {in_regime[REGIME_BW], in_regime};
    assign sat_hi = k_ext > K_MAX;
    assign sat_lo = k_ext < K_MIN;
    assign k_c    = sat_hi ? K_MAX : (sat_lo ? K_MIN : k_ext);
    assign k_neg  = k_c[KW-1];
    assign run    = k_neg ? RUN_W'(-k_c) : RUN_W'(k_c + KW'(1));
    // The terminator bit only exists while the run leaves room for it.
    assign term   = run < RUN_W'(POSIT_LEN - 1);
    assign rl     = run + RUN_W'(term);

    always_comb begin
        regime_pat = '0;
        if (!k_neg) begin
            regime_pat = ~({BW{1'b1}} >> run);
        end else if (term) begin
            regime_pat = {1'b1, {(BW-1){1'b0}}} >> run;
        end
    end

    assign tail_al = {in_exponent, in_fraction, in_guard, {(BW-TAIL_W){1'b0}}};
    assign body    = regime_pat | (tail_al >> rl);

    logic [POSIT_LEN-1:0] s1_body_d, s1_body_q;
    logic                 s1_sticky_d, s1_sticky_q;
    logic                 s1_sign_q, s1_sat_hi_q, s1_sat_lo_q, s1_zero_q, s1_nar_q;

    assign s1_body_d   = body[BW-1:POSIT_LEN];
    assign s1_sticky_d = in_sticky | (|body[POSIT_LEN-1:0]);

    // ---------------- stage 2: round, clamp magnitude, apply sign ----------------
    logic [POSIT_LEN-2:0] kept, mag_c;
    logic                 lsb, grd, round_up;
    logic [POSIT_LEN:0]   mag_inc;
    logic [POSIT_LEN-1:0] pos_mag, signed_res, s2_posit_d, s2_posit_q;

    assign kept     = s1_body_q[POSIT_LEN-1:1];
    assign lsb      = s1_body_q[1];
    assign grd      = s1_body_q[0];
    assign round_up = grd & (s1_sticky_q | lsb);
    assign mag_inc  = {2'b00, kept} + {{POSIT_LEN{1'b0}}, round_up};

    always_comb begin
        mag_c = mag_inc[POSIT_LEN-2:0];
        if (s1_sat_hi_q || (mag_inc > MAXPOS)) begin
            mag_c = {(POSIT_LEN-1){1'b1}};
        end else if (s1_sat_lo_q || (mag_inc == '0)) begin
            mag_c = (POSIT_LEN-1)'(1);
        end
    end

    assign pos_mag    = {1'b0, mag_c};
    assign signed_res = s1_sign_q ? (~pos_mag + POSIT_LEN'(1)) : pos_mag;

    always_comb begin
        s2_posit_d = signed_res;
        if (s1_nar_q) begin
            s2_posit_d = {1'b1, {(POSIT_LEN-1){1'b0}}};
        end else if (s1_zero_q) begin
            s2_posit_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s1_valid_q  <= 1'b0;
            s1_body_q   <= '0;
            s1_sticky_q <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_sat_hi_q <= 1'b0;
            s1_sat_lo_q <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_nar_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_posit_q  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_body_q   <= s1_body_d;
                s1_sticky_q <= s1_sticky_d;
                s1_sign_q   <= in_sign;
                s1_sat_hi_q <= sat_hi;
                s1_sat_lo_q <= sat_lo;
                s1_zero_q   <= in_zero;
                s1_nar_q    <= in_nar;
            end
            if (s1_move) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s1_valid_q && s1_move) begin
                s2_posit_q <= s2_posit_d;
            end
        end
    end

    assign out_posit = s2_posit_q;

endmodule

// File: tb/tb_eh2_posit_encode_pipe.sv
// Bench for eh2_posit_encode_pipe: directed encodings, random bursts under random back-pressure,
// and reset with results in flight, all checked through an expected-value queue.
module tb_eh2_posit_encode_pipe;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sign = 1'b0;
    logic [5:0]    in_regime = '0;
    logic [1:0]    in_exponent = '0;
    logic [26:0]   in_fraction = '0;
    logic          in_guard = 1'b0;
    logic          in_sticky = 1'b0;
    logic          in_zero = 1'b0;
    logic          in_nar = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_posit;

    eh2_posit_encode_pipe #(.POSIT_LEN(32), .ES(2)) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_regime   (in_regime),
        .in_exponent (in_exponent),
        .in_fraction (in_fraction),
        .in_guard    (in_guard),
        .in_sticky   (in_sticky),
        .in_zero     (in_zero),
        .in_nar      (in_nar),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_posit   (out_posit)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int           total = 0;
    int           bad = 0;
    logic [N-1:0] exp_q[$];
    int           acc_q[$];
    bit           mon_en = 1'b0;
    bit           lat_chk = 1'b0;
    bit           rand_rdy = 1'b0;
    int           occ;
    int           acc_edge;
    logic [N-1:0] exp_v;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            occ = exp_q.size();
            chk("in_ready", {31'b0, in_ready}, {31'b0, !(occ == 2 && !out_ready)});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_out", {31'b0, out_valid}, '0);
                end else begin
                    exp_v    = exp_q.pop_front();
                    acc_edge = acc_q.pop_front();
                    chk("posit", out_posit, exp_v);
                    if (lat_chk) chk("latency", N'(cyc + 1 - acc_edge), 32'd2);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [N-1:0] model(input logic sg, input logic [5:0] kraw,
                                           input logic [1:0] e, input logic [26:0] f,
                                           input logic g, input logic s,
                                           input logic z, input logic n);
        int          k;
        int          p;
        logic [95:0] str;
        logic [32:0] m;
        logic        gg;
        logic        ss;
        k = int'($signed(kraw));
        if (n) return 32'h8000_0000;
        if (z) return 32'h0;
        if (k > 30) begin
            m = 33'h7FFF_FFFF;
        end else if (k < -31) begin
            m = 33'h1;
        end else begin
            str = '0;
            p = 95;
            if (k >= 0) begin
                for (int i = 0; i < k + 1; i++) begin
                    str[p] = 1'b1;
                    p--;
                end
                if (k + 1 < 31) p--;
            end else begin
                p = 95 + k;
                if (-k < 31) begin
                    str[p] = 1'b1;
                    p--;
                end
            end
            for (int i = 1; i >= 0; i--) begin
                str[p] = e[i];
                p--;
            end
            for (int i = 26; i >= 0; i--) begin
                str[p] = f[i];
                p--;
            end
            str[p] = g;
            gg = str[64];
            ss = s | (|str[63:0]);
            m  = {2'b00, str[95:65]} + {32'b0, gg & (ss | str[65])};
            if (m > 33'h7FFF_FFFF) m = 33'h7FFF_FFFF;
            if (m == 33'h0) m = 33'h1;
        end
        return sg ? (~m[31:0] + 32'd1) : m[31:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic sg, input int k, input logic [1:0] e, input logic [26:0] f,
                        input logic g, input logic s, input logic z, input logic n,
                        input logic [N-1:0] exp);
        int guard;
        logic [31:0] kv;
        kv = k;
        @(negedge clk);
        in_sign = sg;
        in_regime = kv[5:0];
        in_exponent = e;
        in_fraction = f;
        in_guard = g;
        in_sticky = s;
        in_zero = z;
        in_nar = n;
        in_valid = 1'b1;
        #2;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            #2;
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {31'b0, in_ready}, 32'd1);
        end else begin
            exp_q.push_back(exp);
            acc_q.push_back(cyc + 1);
        end
    endtask

    task automatic send_rand();
        logic        sg;
        logic [5:0]  k6;
        logic [1:0]  e;
        logic [26:0] f;
        logic        g;
        logic        s;
        logic        z;
        logic        n;
        int          kk;
        sg = 1'($urandom_range(0, 1));
        k6 = 6'($urandom_range(0, 63));
        e  = 2'($urandom_range(0, 3));
        f  = 27'($urandom);
        g  = 1'($urandom_range(0, 1));
        s  = 1'($urandom_range(0, 1));
        z  = ($urandom_range(0, 7) == 0);
        n  = ($urandom_range(0, 15) == 0);
        kk = int'($signed(k6));
        send(sg, kk, e, f, g, s, z, n, model(sg, k6, e, f, g, s, z, n));
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", N'(exp_q.size()), '0);
    endtask

    task automatic dsend(input logic sg, input int k, input logic [1:0] e, input logic [26:0] f,
                         input logic g, input logic s, input logic z, input logic n,
                         input logic [N-1:0] exp);
        send(sg, k, e, f, g, s, z, n, exp);
        drain();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, '0);
        chk("rst_out_posit", out_posit, '0);
        rst_l = 1'b1;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid_rel", {31'b0, out_valid}, '0);

        out_ready = 1'b1;
        mon_en = 1'b1;
        lat_chk = 1'b1;
        dsend(0,   0, 2'd0, 27'h0,        0, 0, 0, 0, 32'h4000_0000);
        dsend(1,   0, 2'd0, 27'h0,        0, 0, 0, 0, 32'hC000_0000);
        dsend(0,   1, 2'd0, 27'h0,        0, 0, 0, 0, 32'h6000_0000);
        dsend(0,   0, 2'd1, 27'h0,        0, 0, 0, 0, 32'h4800_0000);
        dsend(0,  -1, 2'd0, 27'h0,        0, 0, 0, 0, 32'h2000_0000);
        dsend(0,   0, 2'd0, 27'h7FF_FFFF, 1, 0, 0, 0, 32'h4800_0000);
        dsend(0,   0, 2'd0, 27'h0,        1, 0, 0, 0, 32'h4000_0000);
        dsend(0,   0, 2'd0, 27'h1,        1, 0, 0, 0, 32'h4000_0002);
        dsend(0,   0, 2'd0, 27'h0,        1, 1, 0, 0, 32'h4000_0001);
        dsend(0,  31, 2'd3, 27'h7FF_FFFF, 1, 1, 0, 0, 32'h7FFF_FFFF);
        dsend(1,  31, 2'd0, 27'h0,        0, 0, 0, 0, 32'h8000_0001);
        dsend(0, -32, 2'd0, 27'h0,        0, 0, 0, 0, 32'h0000_0001);
        dsend(1, -32, 2'd0, 27'h0,        0, 0, 0, 0, 32'hFFFF_FFFF);
        dsend(0, -30, 2'd0, 27'h0,        0, 0, 0, 0, 32'h0000_0001);
        dsend(0,   3, 2'd2, 27'h123,      0, 0, 1, 1, 32'h8000_0000);
        dsend(1,   3, 2'd2, 27'h123,      1, 1, 1, 0, 32'h0000_0000);

        lat_chk = 1'b0;
        rand_rdy = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) send_rand();
            drain();
        end
        rand_rdy = 1'b0;
        @(negedge clk);
        #3;
        out_ready = 1'b1;

        // two results in flight, then reset
        out_ready = 1'b0;
        send(0, 1, 2'd0, 27'h0, 0, 0, 0, 0, 32'h6000_0000);
        send(0, 2, 2'd0, 27'h0, 0, 0, 0, 0, 32'h7000_0000);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        mon_en = 1'b0;
        rst_l = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, '0);
        chk("midrst_out_posit", out_posit, '0);
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("postrst_out_valid", {31'b0, out_valid}, '0);
            chk("postrst_out_posit", out_posit, '0);
        end
        mon_en = 1'b1;
        lat_chk = 1'b1;
        dsend(0, -1, 2'd1, 27'h0, 0, 0, 0, 0, 32'h2800_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
